// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: bit-serial adder that reuses one full-adder cell (two
// half-adders plus an OR) across a WIDTH-bit operand pair, LSB first, with
// valid/ready handshakes on both the operand and the result side.
// Optional feature macro: SERIAL_ADD_OVF_EN adds the out_ovf signed-overflow output.
module serial_add_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic ha1_s, ha1_c, ha2_s, ha2_c, fa_cout;

  // Single full-adder cell: two half-adder stages and an OR for the carry.
  always_comb begin
    ha1_s   = a_sr[0] ^ b_sr[0];
    ha1_c   = a_sr[0] & b_sr[0];
    ha2_s   = ha1_s ^ carry;
    ha2_c   = ha1_s & carry;
    fa_cout = ha1_c | ha2_c;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic plus the accept/last-bit strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept    = 1'b1;
          state_nxt = ADD;
        end
      end
      ADD: begin
        last = (cnt == LAST);
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake/status outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      busy      <= (state_nxt != IDLE);
    end
  end

  // Operand load, per-bit shift/carry update, and result capture on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      sum_sr   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      out_ovf  <= 1'b0;
`endif
    end else if (accept) begin
      a_sr  <= in_a;
      b_sr  <= in_b;
      carry <= in_cin;
      cnt   <= '0;
    end else if (state == ADD) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      carry  <= fa_cout;
      sum_sr <= WIDTH'({ha2_s, sum_sr} >> 1);
      cnt    <= last ? '0 : cnt + CW'(1);
      if (last) begin
        out_sum  <= WIDTH'({ha2_s, sum_sr} >> 1);
        out_cout <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
        // Carry into the MSB is the pre-update carry; carry out is fa_cout.
        out_ovf  <= carry ^ fa_cout;
`endif
      end
    end
  end

endmodule
